bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one input bit per clock.
- Produces the packed BCD digit bus that drives the per-digit bcd_decode seven-segment instances in the TDC display path.
- Accepts a binary count through a start/busy/done handshake.
- Registers the result, including a saturating overflow flag and a leading-zero blank mask.

---
 rtl/bin2bcd_seq_pkg.sv | 21 ++
 rtl/bin2bcd_seq_bcd_add3.sv | 14 +
 rtl/bin2bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_BIN_W  = 14;
  localparam int unsigned DEF_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;

  function automatic int unsigned max_val(input int unsigned digits);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= DIGIT_W'(5)) dout = din + DIGIT_W'(3);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with
// start/busy/done handshake, saturating overflow flag and leading-zero blank mask.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = DEF_BIN_W,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      ovf,
  output logic [DIGITS-1:0]         blank
);

  localparam int unsigned BCD_W   = DIGITS * DIGIT_W;
  localparam int unsigned ACC_W   = BCD_W + 1;
  localparam int unsigned MAX_VAL = max_val(DIGITS);
  localparam int unsigned CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [BIN_W:0] MAX_CMP = (BIN_W + 1)'(MAX_VAL);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [DIGITS-1:0]  blank_q, blank_d;

  logic [BCD_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_shift;
  logic [BIN_W-1:0]   sr_shift;
  logic               sat;
  logic [BCD_W-1:0]   bcd_res;
  logic [DIGITS-1:0]  blank_res;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (acc_q[g*DIGIT_W +: DIGIT_W]),
      .dout (acc_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // The top accumulator bit is sticky so a carry out of the last digit is
  // never lost to the shift; it forces saturation alongside ovf_pend.
  always_comb begin
    acc_shift = {acc_q[BCD_W] | acc_adj[BCD_W-1], acc_adj[BCD_W-2:0], sr_q[BIN_W-1]};
    sr_shift  = {sr_q[BIN_W-2:0], 1'b0};
    sat       = ovf_pend_q | acc_shift[BCD_W];
    bcd_res   = sat ? {DIGITS{4'd9}} : acc_shift[BCD_W-1:0];
    blank_res = '0;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      blank_res[i] = ((bcd_res >> (DIGIT_W * i)) == '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    blank_d    = blank_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d       = bin;
          acc_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = ({1'b0, bin} > MAX_CMP);
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        acc_d = acc_shift;
        cnt_d = cnt_q + CNT_W'(1);
        // Results load on the final shift edge so they rise together with done.
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          bcd_d   = bcd_res;
          ovf_d   = ovf_pend_q;
          blank_d = blank_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      blank_q    <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      blank_q    <= blank_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;
  assign blank = blank_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed-vector bench for bin2bcd_seq: table of conversions plus abort,
// ignored-start and back-to-back sequences.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;
  logic [3:0]  blank;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bin2bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf),
    .blank (blank)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } vec_t;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int unsigned v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] ref_blank(input logic [15:0] b);
    logic [3:0] r;
    r    = 4'b0000;
    r[3] = (b[15:12] == 4'd0);
    r[2] = (b[15:8] == 8'd0);
    r[1] = (b[15:4] == 12'd0);
    return r;
  endfunction

  // Starts a conversion on the next negedge (expected IDLE) and returns at the
  // negedge where done is seen, with the number of cycles since the start edge.
  task automatic do_conv(input logic [13:0] v, output int lat);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    start = 1'b1;
    bin   = v;
    @(negedge clk);
    start = 1'b0;
    bin   = ~v;
    lat   = 1;
    while (!done && lat < 40) begin
      chk("busy_during", busy, 1);
      @(negedge clk);
      lat++;
    end
    chk("busy_at_done", busy, 1);
  endtask

  vec_t vecs[9];
  int   lat;
  int   prev_t;
  int   seen;

  initial begin
    vecs[0] = '{14'd1234,  16'h1234, 1'b0, 4'b0000};
    vecs[1] = '{14'd7,     16'h0007, 1'b0, 4'b1110};
    vecs[2] = '{14'd0,     16'h0000, 1'b0, 4'b1110};
    vecs[3] = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
    vecs[4] = '{14'd10000, 16'h9999, 1'b1, 4'b0000};
    vecs[5] = '{14'd16383, 16'h9999, 1'b1, 4'b0000};
    vecs[6] = '{14'd50,    16'h0050, 1'b0, 4'b1100};
    vecs[7] = '{14'd100,   16'h0100, 1'b0, 4'b1000};
    vecs[8] = '{14'd9998,  16'h9998, 1'b0, 4'b0000};

    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_blank", blank, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_conv(vecs[i].bin, lat);
      chk("tbl_latency", lat, 15);
      chk("tbl_bcd", bcd, vecs[i].bcd);
      chk("tbl_ovf", ovf, vecs[i].ovf);
      chk("tbl_blank", blank, vecs[i].blank);
    end

    // start pulses at +3 and in the done cycle are ignored
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd2718;
    @(negedge clk);
    start = 1'b0;
    bin   = 14'd42;
    lat   = 1;
    while (!done && lat < 40) begin
      start = (lat == 3);
      @(negedge clk);
      lat++;
    end
    chk("ign_latency", lat, 15);
    chk("ign_bcd", bcd, 16'h2718);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy_after", busy, 0);
    chk("ign_done_after", done, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    chk("ign_no_second", seen, 0);
    chk("ign_bcd_hold", bcd, 16'h2718);

    // reset mid-conversion, with start asserted alongside it
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_blank", blank, 0);
    rst   = 1'b0;
    start = 1'b0;
    seen  = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) seen++;
    end
    chk("abort_no_done", seen, 0);
    do_conv(14'd4321, lat);
    chk("abort_latency", lat, 15);
    chk("abort_bcd_new", bcd, 16'h4321);
    chk("abort_blank_new", blank, 0);

    // back-to-back conversions across the input range
    prev_t = 0;
    for (int v = 0; v < 16384; v += 5) begin
      do_conv(14'(v), lat);
      chk("sweep_latency", lat, 15);
      chk("sweep_bcd", bcd, ref_bcd(v));
      chk("sweep_ovf", ovf, (v > 9999) ? 1 : 0);
      chk("sweep_blank", blank, ref_blank(ref_bcd(v)));
      if (v != 0) chk("sweep_spacing", cyc - prev_t, 16);
      prev_t = cyc;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
